fp_to_gp_wb_buffer: RTL and testbench

- Result buffer directly downstream of the single-precision FP-to-GP unit.
- Captures each completed result (rd, id) on the unit's writeback done/ack handshake.
- Replays results in order to the writeback arbiter over a second done/ack handshake.
- Lets the FP-to-GP unit retire and accept new issues while the arbiter is busy; no combinational path from arbiter ack to unit ack.

---
 rtl/fp_to_gp_wb_buffer.sv | 82 ++++++++
 tb/tb_fp_to_gp_wb_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_to_gp_wb_buffer.sv
// Result FIFO between the FP-to-GP unit and the writeback arbiter.
// Decouples unit retirement from arbiter grants; no ack-to-ack path.
module fp_to_gp_wb_buffer #(
  parameter int DEPTH = 2,
  parameter int ID_W  = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_done,
  input  logic [ID_W-1:0]  in_id,
  input  logic [31:0]      in_rd,
  output logic             in_ack,
  output logic             out_done,
  output logic [ID_W-1:0]  out_id,
  output logic [31:0]      out_rd,
  input  logic             out_ack,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ID_W-1:0]  idMem [DEPTH];
  logic [31:0]      rdMem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             pushEn;
  logic             popEn;

  function automatic logic [PTR_W-1:0] nextPtr(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Full check uses registered occupancy only, so out_ack never reaches in_ack.
  assign in_ack   = in_done && (occupancy != FULL);
  assign out_done = (occupancy != '0);
  assign pushEn   = in_ack;
  assign popEn    = out_done && out_ack;
  assign out_id   = idMem[rdPtr];
  assign out_rd   = rdMem[rdPtr];

  always_ff @(posedge clk) begin
    if (pushEn) begin
      idMem[wrPtr] <= in_id;
      rdMem[wrPtr] <= in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (pushEn) wrPtr <= nextPtr(wrPtr);
      if (popEn)  rdPtr <= nextPtr(rdPtr);
      unique case ({pushEn, popEn})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert (occupancy <= FULL)
        else $error("occupancy above DEPTH");
      assert (!(popEn && occupancy == '0))
        else $error("occupancy underflow");
      assert (!(in_ack && !in_done))
        else $error("in_ack without in_done");
    end
  end
`endif

endmodule

// File: tb/tb_fp_to_gp_wb_buffer.sv
// Directed bench for fp_to_gp_wb_buffer.
// Covers DEPTH=2 behaviour plus a DEPTH=1 build.
module tb_fp_to_gp_wb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        inDone, outAck, inAck, outDone;
  logic [2:0]  inId, outId;
  logic [31:0] inRd, outRd;
  logic [1:0]  occ;

  logic        d1InDone, d1OutAck, d1InAck, d1OutDone;
  logic [2:0]  d1InId, d1OutId;
  logic [31:0] d1InRd, d1OutRd;
  logic [0:0]  d1Occ;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  fp_to_gp_wb_buffer #(.DEPTH(2), .ID_W(3)) u0 (
    .clk(clk), .rst(rst),
    .in_done(inDone), .in_id(inId), .in_rd(inRd),
    .in_ack(inAck),
    .out_done(outDone), .out_id(outId), .out_rd(outRd),
    .out_ack(outAck), .occupancy(occ)
  );

  fp_to_gp_wb_buffer #(.DEPTH(1), .ID_W(3)) u1 (
    .clk(clk), .rst(rst),
    .in_done(d1InDone), .in_id(d1InId), .in_rd(d1InRd),
    .in_ack(d1InAck),
    .out_done(d1OutDone), .out_id(d1OutId), .out_rd(d1OutRd),
    .out_ack(d1OutAck), .occupancy(d1Occ)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleChk(input string tag);
    chk({tag, "_occ"}, 32'(occ), 32'd0);
    chk({tag, "_odone"}, 32'(outDone), 32'd0);
    chk({tag, "_iack"}, 32'(inAck), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    inDone = 0; outAck = 0; inId = 0; inRd = 0;
    d1InDone = 0; d1OutAck = 0; d1InId = 0; d1InRd = 0;

    tick();
    idleChk("rst0");
    tick();
    idleChk("rst1");
    rst = 1'b1;
    tick();
    idleChk("idle0");
    tick();
    idleChk("idle1");

    // single pass
    inDone = 1; inId = 3'd5; inRd = 32'h7FFF_FFFF;
    #1 chk("sp_iack", 32'(inAck), 32'd1);
    tick();
    inDone = 0;
    for (int i = 0; i < 5; i++) begin
      chk("sp_odone", 32'(outDone), 32'd1);
      chk("sp_id", 32'(outId), 32'd5);
      chk("sp_rd", outRd, 32'h7FFF_FFFF);
      chk("sp_occ", 32'(occ), 32'd1);
      if (i < 4) tick();
    end
    outAck = 1;
    tick();
    outAck = 0;
    chk("sp_occ0", 32'(occ), 32'd0);
    chk("sp_odone0", 32'(outDone), 32'd0);

    // async reset mid-cycle discards held entry
    inDone = 1; inId = 3'd6; inRd = 32'h66;
    tick();
    inDone = 0;
    chk("mr_occ1", 32'(occ), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mr_occ0", 32'(occ), 32'd0);
    chk("mr_odone", 32'(outDone), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    idleChk("mr_idle");

    // fill and stall
    inDone = 1; inId = 3'd1; inRd = 32'h1;
    tick();
    inId = 3'd2; inRd = 32'h2;
    tick();
    inId = 3'd3; inRd = 32'h3;
    #1;
    chk("fs_occ2", 32'(occ), 32'd2);
    chk("fs_iack_full", 32'(inAck), 32'd0);
    chk("fs_head1", 32'(outId), 32'd1);
    chk("fs_rd1", outRd, 32'h1);
    outAck = 1;
    #1 chk("fs_iack_full_ack", 32'(inAck), 32'd0);
    tick();
    chk("fs_occ_pop", 32'(occ), 32'd1);
    chk("fs_iack3", 32'(inAck), 32'd1);
    chk("fs_head2", 32'(outId), 32'd2);
    chk("fs_rd2", outRd, 32'h2);
    tick();
    inDone = 0;
    chk("fs_occ_pp", 32'(occ), 32'd1);
    chk("fs_head3", 32'(outId), 32'd3);
    chk("fs_rd3", outRd, 32'h3);
    tick();
    outAck = 0;
    chk("fs_empty", 32'(outDone), 32'd0);
    chk("fs_occ0", 32'(occ), 32'd0);

    // simultaneous push/pop at occupancy 1
    inDone = 1; inId = 3'd7; inRd = 32'h11;
    tick();
    inDone = 1; inId = 3'd4; inRd = 32'hA5A5_A5A5;
    outAck = 1;
    #1;
    chk("pp_occ1", 32'(occ), 32'd1);
    chk("pp_iack", 32'(inAck), 32'd1);
    chk("pp_head7", 32'(outId), 32'd7);
    tick();
    inDone = 0; outAck = 0;
    chk("pp_occ", 32'(occ), 32'd1);
    chk("pp_head4", 32'(outId), 32'd4);
    chk("pp_rd", outRd, 32'hA5A5_A5A5);
    outAck = 1;
    tick();
    outAck = 0;
    chk("pp_occ0", 32'(occ), 32'd0);

    // streaming, 20 results, 10 pointer laps
    for (int c = 0; c < 20; c++) begin
      inDone = 1; inId = 3'(c % 8); inRd = 32'(c);
      outAck = 1;
      #1;
      chk("st_iack", 32'(inAck), 32'd1);
      if (c > 0) begin
        chk("st_odone", 32'(outDone), 32'd1);
        chk("st_id", 32'(outId), 32'((c - 1) % 8));
        chk("st_rd", outRd, 32'(c - 1));
      end
      tick();
    end
    inDone = 0;
    chk("st_last_id", 32'(outId), 32'd3);
    chk("st_last_rd", outRd, 32'd19);
    tick();
    outAck = 0;
    chk("st_occ0", 32'(occ), 32'd0);

    // DEPTH=1: accept every other cycle, deliver each once
    for (int k = 0; k < 12; k++) begin
      d1InDone = 1; d1OutAck = 1;
      d1InId = 3'(((k + 1) / 2) % 8);
      d1InRd = 32'((k + 1) / 2);
      #1;
      chk("d1_iack", 32'(d1InAck), 32'(k % 2 == 0));
      chk("d1_occ", 32'(d1Occ), 32'(k % 2));
      chk("d1_odone", 32'(d1OutDone), 32'(k % 2));
      if (k % 2 == 1) begin
        chk("d1_rd", d1OutRd, 32'((k - 1) / 2));
        chk("d1_id", 32'(d1OutId), 32'(((k - 1) / 2) % 8));
      end
      tick();
    end
    d1InDone = 0; d1OutAck = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule
